// File: rtl/gmac_init_pkg.sv
// Shared constants and types for the MAC power-up configurator.
package gmac_init_pkg;

  // MAC register word addresses
  localparam logic [7:0] CMD_CONFIG    = 8'h02;
  localparam logic [7:0] MAC_0         = 8'h03;
  localparam logic [7:0] MAC_1         = 8'h04;
  localparam logic [7:0] FRM_LENGTH    = 8'h05;
  localparam logic [7:0] TX_IPG_LENGTH = 8'h17;

  // command_config bit that self-clears when the MAC soft reset finishes
  localparam int unsigned SW_RESET_BIT = 13;

  typedef enum logic [2:0] {
    StWait,
    StStep,
    StAcc,
    StNext,
    StDone
  } state_e;

  typedef enum logic {
    OpWr,
    OpRd
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
  } step_t;

  function automatic step_t mk_step(op_e op, logic [7:0] addr, logic [31:0] data);
    step_t s;
    s.op   = op;
    s.addr = addr;
    s.data = data;
    return s;
  endfunction

endpackage

// File: rtl/gmac_init_if.sv
// Avalon-MM style control-port bundle between the configurator and the MAC.
interface gmac_init_if;
  logic [7:0]  o_addr;
  logic        o_wr;
  logic        o_rd;
  logic [31:0] o_wr_data;
  logic [31:0] i_rd_data;
  logic        i_wtrq;

  modport master (
    output o_addr,
    output o_wr,
    output o_rd,
    output o_wr_data,
    input  i_rd_data,
    input  i_wtrq
  );

  modport slave (
    input  o_addr,
    input  o_wr,
    input  o_rd,
    input  o_wr_data,
    output i_rd_data,
    output i_wtrq
  );
endinterface

// File: rtl/gmac_init.sv
// Power-up configurator: after reset, waits START_DLY cycles, then runs a fixed
// write/read sequence on the MAC control port and raises o_done.
module gmac_init
  import gmac_init_pkg::*;
#(
  parameter int unsigned START_DLY = 1000,
  parameter logic [47:0] MAC_ADDR  = 48'h00_1C_23_17_4A_CB,
  parameter logic [31:0] FRM_LEN   = 32'd1518,
  parameter logic [31:0] TX_IPG    = 32'd12,
  parameter logic [31:0] CMD_CFG   = 32'h0000_001B,
  parameter int unsigned POLL_MAX  = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  gmac_init_if.master      bus,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned      CNT_W     = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int unsigned      POLL_W    = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(START_DLY - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [2:0]       STEP_POLL = 3'd1;
  localparam logic [2:0]       STEP_LAST = 3'd7;

  state_e              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [2:0]          r_step, w_step;
  logic [POLL_W-1:0]   r_poll, w_poll;
  logic                r_wr, w_wr;
  logic                r_rd, w_rd;
  logic [7:0]          r_addr, w_addr;
  logic [31:0]         r_wr_data, w_wr_data;
  logic                r_done, w_done;
  logic                r_err, w_err;
  step_t               w_tbl;

  // Step table: operation, address and write data for the current step index
  always_comb begin
    unique case (r_step)
      3'd0: w_tbl = mk_step(OpWr, CMD_CONFIG, 32'(1) << SW_RESET_BIT);
      3'd1: w_tbl = mk_step(OpRd, CMD_CONFIG, 32'h0);
      3'd2: w_tbl = mk_step(OpWr, MAC_0,
                            {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]});
      3'd3: w_tbl = mk_step(OpWr, MAC_1, {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]});
      3'd4: w_tbl = mk_step(OpWr, FRM_LENGTH, FRM_LEN);
      3'd5: w_tbl = mk_step(OpWr, TX_IPG_LENGTH, TX_IPG);
      3'd6: w_tbl = mk_step(OpWr, CMD_CONFIG, CMD_CFG);
      3'd7: w_tbl = mk_step(OpRd, CMD_CONFIG, 32'h0);
      default: w_tbl = mk_step(OpRd, CMD_CONFIG, 32'h0);
    endcase
  end

  // Next-state and registered-output logic for the sequencer
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_step    = r_step;
    w_poll    = r_poll;
    w_wr      = r_wr;
    w_rd      = r_rd;
    w_addr    = r_addr;
    w_wr_data = r_wr_data;
    w_done    = r_done;
    w_err     = r_err;

    unique case (r_state)
      StWait: begin
        if (r_cnt == CNT_LAST) begin
          w_state = StStep;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      StStep: begin
        w_wr      = (w_tbl.op == OpWr);
        w_rd      = (w_tbl.op == OpRd);
        w_addr    = w_tbl.addr;
        w_wr_data = (w_tbl.op == OpWr) ? w_tbl.data : 32'h0;
        w_state   = StAcc;
      end
      StAcc: begin
        // Outputs are held untouched while the slave stalls
        if (!bus.i_wtrq) begin
          w_wr    = 1'b0;
          w_rd    = 1'b0;
          w_state = StNext;
          if (r_step == STEP_POLL && bus.i_rd_data[SW_RESET_BIT]) begin
            // Soft reset still pending: re-read unless the poll budget is spent
            if (r_poll == POLL_LAST) begin
              w_err  = 1'b1;
              w_step = r_step + 3'd1;
            end else begin
              w_poll = r_poll + 1'b1;
            end
          end else if (r_step == STEP_LAST) begin
            w_state = StDone;
          end else begin
            w_step = r_step + 3'd1;
          end
        end
      end
      StNext: begin
        w_state = StStep;
      end
      StDone: begin
        w_done = 1'b1;
      end
      default: begin
        w_state = StWait;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StWait;
      r_cnt     <= '0;
      r_step    <= '0;
      r_poll    <= '0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_step    <= w_step;
      r_poll    <= w_poll;
      r_wr      <= w_wr;
      r_rd      <= w_rd;
      r_addr    <= w_addr;
      r_wr_data <= w_wr_data;
      r_done    <= w_done;
      r_err     <= w_err;
    end
  end

  assign bus.o_addr    = r_addr;
  assign bus.o_wr      = r_wr;
  assign bus.o_rd      = r_rd;
  assign bus.o_wr_data = r_wr_data;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_gmac_init.sv
// Directed bench for gmac_init: scoreboard of expected accesses, reactive slave model.
module tb_gmac_init;
  import gmac_init_pkg::*;

  localparam int unsigned START_DLY = 1000;
  localparam int unsigned POLL_MAX  = 1023;
  localparam logic [47:0] MAC_ADDR  = 48'h00_1C_23_17_4A_CB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_done;
  logic o_err;

  gmac_init_if bus ();

  gmac_init #(
    .START_DLY (START_DLY),
    .MAC_ADDR  (MAC_ADDR),
    .FRM_LEN   (32'd1518),
    .TX_IPG    (32'd12),
    .CMD_CFG   (32'h0000_001B),
    .POLL_MAX  (POLL_MAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_done (o_done),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } acc_t;

  acc_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   wait_cycles = 0;
  int   poll_cfg = 0;   // reads returning SW_RESET set; negative means forever
  int   ones_left = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Slave model: stalls each access wait_cycles cycles, answers polls per poll_cfg
  initial begin
    int   st;
    logic rd_done;
    st = 0;
    bus.i_wtrq    = 1'b0;
    bus.i_rd_data = 32'h0;
    forever begin
      @(negedge clk);
      rd_done = rst_n && bus.o_rd && !bus.i_wtrq;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ones_left  = poll_cfg;
        st         = 0;
        bus.i_wtrq = 1'b0;
      end else begin
        if (rd_done && ones_left > 0) ones_left--;
        if (bus.o_wr || bus.o_rd) begin
          if (st < wait_cycles) begin
            bus.i_wtrq = 1'b1;
            st++;
          end else begin
            bus.i_wtrq = 1'b0;
          end
        end else begin
          bus.i_wtrq = 1'b0;
          st = 0;
        end
      end
      bus.i_rd_data = (ones_left != 0) ? 32'h0000_2000 : 32'h0;
    end
  end

  task automatic push_acc(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    acc_t a;
    a.wr = wr;
    a.addr = addr;
    a.data = data;
    exp_q.push_back(a);
  endtask

  task automatic push_seq(input int n_poll);
    exp_q.delete();
    push_acc(1'b1, 8'h02, 32'h0000_2000);
    for (int i = 0; i < n_poll; i++) push_acc(1'b0, 8'h02, 32'h0);
    push_acc(1'b1, 8'h03, 32'h1723_1C00);
    push_acc(1'b1, 8'h04, 32'h0000_CB4A);
    push_acc(1'b1, 8'h05, 32'd1518);
    push_acc(1'b1, 8'h17, 32'd12);
    push_acc(1'b1, 8'h02, 32'h0000_001B);
    push_acc(1'b0, 8'h02, 32'h0);
  endtask

  // Watches the bus at falling edges; completes entries from the scoreboard.
  // Returns early (hit=1) if use_stop and a strobe to stop_addr appears.
  task automatic run_seq(input int budget, input bit use_stop, input logic [7:0] stop_addr,
                         output int first_wr, output bit hit);
    logic        prev_hold;
    logic [41:0] prev_vec;
    logic [41:0] cur_vec;
    acc_t        e;
    prev_hold = 1'b0;
    prev_vec  = '0;
    first_wr  = -1;
    hit       = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      cur_vec = {bus.o_wr, bus.o_rd, bus.o_addr, bus.o_wr_data};
      chk("wr_rd_exclusive", 64'(bus.o_wr & bus.o_rd), 64'd0);
      if (prev_hold) chk("held_during_wtrq", 64'(cur_vec), 64'(prev_vec));
      if (bus.o_wr && first_wr < 0) first_wr = cyc;
      if (use_stop && (bus.o_wr || bus.o_rd) && bus.o_addr == stop_addr) begin
        hit = 1'b1;
        return;
      end
      if ((bus.o_wr || bus.o_rd) && !bus.i_wtrq) begin
        chk("access_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("acc_kind", 64'({bus.o_wr, bus.o_rd}), 64'({e.wr, ~e.wr}));
          chk("acc_addr", 64'(bus.o_addr), 64'(e.addr));
          if (e.wr) chk("acc_wdata", 64'(bus.o_wr_data), 64'(e.data));
        end
      end
      prev_hold = (bus.o_wr || bus.o_rd) && bus.i_wtrq;
      prev_vec  = cur_vec;
      if (o_done) break;
    end
    if (!use_stop) begin
      chk("done_within_budget", 64'(o_done), 64'd1);
      chk("all_accesses_seen", 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_after_done();
    repeat (10) begin
      @(negedge clk);
      chk("idle_no_strobe", 64'(bus.o_wr | bus.o_rd), 64'd0);
      chk("done_sticky", 64'(o_done), 64'd1);
    end
  endtask

  initial begin
    int fw;
    bit hit;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", 64'(bus.o_addr), 64'd0);
    chk("rst_wr", 64'(bus.o_wr), 64'd0);
    chk("rst_rd", 64'(bus.o_rd), 64'd0);
    chk("rst_wdata", 64'(bus.o_wr_data), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);

    // Plain sequence, no stalls, SW_RESET already clear
    push_seq(1);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(START_DLY + 200, 1'b0, 8'h00, fw, hit);
    // One cycle in STEP after the delay expires before the strobe registers
    chk("first_wr_cycle", 64'(fw), 64'(START_DLY + 1));
    chk("plain_err", 64'(o_err), 64'd0);
    check_idle_after_done();

    // Five wait-request cycles on every access
    wait_cycles = 5;
    apply_reset();
    push_seq(1);
    rst_n = 1'b1;
    run_seq(START_DLY + 300, 1'b0, 8'h00, fw, hit);
    chk("stall_err", 64'(o_err), 64'd0);
    wait_cycles = 0;

    // SW_RESET set for three polls, then clear
    poll_cfg = 3;
    apply_reset();
    push_seq(4);
    rst_n = 1'b1;
    run_seq(START_DLY + 200, 1'b0, 8'h00, fw, hit);
    chk("poll3_err", 64'(o_err), 64'd0);

    // SW_RESET stuck: poll budget exhausted, sequence continues with o_err
    poll_cfg = -1;
    apply_reset();
    push_seq(POLL_MAX);
    rst_n = 1'b1;
    run_seq(START_DLY + 4 * POLL_MAX + 200, 1'b0, 8'h00, fw, hit);
    chk("stuck_err", 64'(o_err), 64'd1);
    check_idle_after_done();

    // Reset pulsed while step 4 (frm_length write) is on the bus
    poll_cfg = 0;
    apply_reset();
    push_seq(1);
    rst_n = 1'b1;
    run_seq(START_DLY + 200, 1'b1, 8'h05, fw, hit);
    chk("reached_step4", 64'(hit), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_wr", 64'(bus.o_wr), 64'd0);
    chk("async_rst_addr", 64'(bus.o_addr), 64'd0);
    chk("async_rst_wdata", 64'(bus.o_wr_data), 64'd0);
    chk("async_rst_done", 64'(o_done), 64'd0);
    repeat (3) @(negedge clk);
    push_seq(1);
    rst_n = 1'b1;
    run_seq(START_DLY + 200, 1'b0, 8'h00, fw, hit);
    chk("replay_first_wr_cycle", 64'(fw), 64'(START_DLY + 1));
    chk("replay_err", 64'(o_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
